// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and helpers for the CNN pipeline stages.
//   state_t   - frame-level FSM encoding (S_IDLE, S_STREAM, S_DONE)
//   N_DEFAULT - default data word width
//   smax      - signed two-input maximum at the default word width
package cnn_pkg;

    localparam int N_DEFAULT = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    function automatic logic signed [N_DEFAULT-1:0] smax(
        input logic signed [N_DEFAULT-1:0] a,
        input logic signed [N_DEFAULT-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_flatten_if.sv
// maxpool_flatten_if: valid/ready pixel stream into the pooling stage.
//   in_valid - producer has a pixel on in_data
//   in_ready - consumer accepts a beat this cycle
//   in_data  - signed pixel, N bits
// Modports: master (producer), slave (pooling stage).
interface maxpool_flatten_if #(
    parameter int N = 16
) ();

    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/max2.sv
// max2: combinational signed two-input maximum.
//   a_i, b_i - signed operands, N bits
//   y_o      - larger of the two (either operand on a tie)
module max2
    import cnn_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    output logic signed [N-1:0] y_o
);

    always_comb begin
        y_o = (a_i > b_i) ? a_i : b_i;
    end

endmodule

// File: rtl/maxpool_flatten.sv
// maxpool_flatten: 2x2 stride-2 max pooling of one single-channel feature
// map, streamed row-major, into a flat buffer read by the dense stage.
//   clk, reset  - clock, asynchronous active-high reset
//   start       - begin a new frame (honoured in S_IDLE / S_DONE only)
//   in_if       - slave pixel stream (in_valid / in_ready / in_data)
//   rd_addr     - flat buffer read index
//   rd_data     - flat_mem[rd_addr], combinational, 0 when out of range
//   busy        - frame in progress
//   done        - one-cycle pulse after the final pixel is accepted
//   flat_valid  - buffer holds a complete pooled frame
// Optional: define MAXPOOL_RELU_EN to clamp negative pixels to zero on
// entry to the pooling datapath.
module maxpool_flatten
    import cnn_pkg::*;
#(
    parameter  int N         = N_DEFAULT,
    parameter  int IN_W      = 8,
    parameter  int IN_H      = 8,
    localparam int FLAT_SIZE = (IN_W / 2) * (IN_H / 2),
    // One spare address code so that an out-of-range read is expressible.
    localparam int AW        = $clog2(FLAT_SIZE + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    maxpool_flatten_if.slave    in_if,
    input  logic [AW-1:0]       rd_addr,
    output logic signed [N-1:0] rd_data,
    output logic                busy,
    output logic                done,
    output logic                flat_valid
);

    localparam int CW = (IN_W > 2) ? $clog2(IN_W) : 1;
    localparam int RW = (IN_H > 2) ? $clog2(IN_H) : 1;
    localparam int LW = (IN_W / 2 > 1) ? $clog2(IN_W / 2) : 1;
    localparam int FW = (FLAT_SIZE > 1) ? $clog2(FLAT_SIZE) : 1;

    if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_in_w
        $error("maxpool_flatten: IN_W must be even and >= 2");
    end
    if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_in_h
        $error("maxpool_flatten: IN_H must be even and >= 2");
    end

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic                done_q, done_d;
    logic signed [N-1:0] pair_q;
    logic signed [N-1:0] linebuf_q [IN_W/2];
    logic signed [N-1:0] flat_mem  [FLAT_SIZE];

    logic                beat;
    logic                in_ready_c;
    logic signed [N-1:0] px;
    logic signed [N-1:0] pair_max;
    logic signed [N-1:0] win_max;
    logic [LW-1:0]       lb_idx;
    logic [FW-1:0]       wr_idx;

`ifdef MAXPOOL_RELU_EN
    assign px = in_if.in_data[N-1] ? '0 : in_if.in_data;
`else
    assign px = in_if.in_data;
`endif

    assign beat           = in_if.in_valid && in_ready_c;
    assign in_if.in_ready = in_ready_c;
    assign done           = done_q;

    assign lb_idx = LW'(col_q >> 1);
    assign wr_idx = FW'((32'(row_q) >> 1) * 32'(IN_W / 2) + (32'(col_q) >> 1));

    // Horizontal pair max, then folded with the row above held in linebuf.
    max2 #(.N(N)) u_pair_max (
        .a_i (pair_q),
        .b_i (px),
        .y_o (pair_max)
    );

    max2 #(.N(N)) u_line_max (
        .a_i (linebuf_q[lb_idx]),
        .b_i (pair_max),
        .y_o (win_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        done_d     = 1'b0;
        in_ready_c = 1'b0;
        busy       = 1'b0;
        flat_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_STREAM: begin
                in_ready_c = 1'b1;
                busy       = 1'b1;
                if (beat) begin
                    if (col_q == CW'(IN_W - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(IN_H - 1)) begin
                            row_d   = '0;
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                flat_valid = 1'b1;
                if (start) begin
                    state_d = S_STREAM;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_q <= '0;
            for (int unsigned i = 0; i < IN_W / 2; i++) begin
                linebuf_q[i] <= '0;
            end
        end else if (beat) begin
            if (!col_q[0]) begin
                pair_q <= px;
            end else if (!row_q[0]) begin
                linebuf_q[lb_idx] <= pair_max;
            end
        end
    end

    // The pooled result buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (beat && col_q[0] && row_q[0]) begin
            flat_mem[wr_idx] <= win_max;
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < FLAT_SIZE) begin
            rd_data = flat_mem[FW'(rd_addr)];
        end
    end

endmodule
